// File: rtl/pci_bus_arbiter_pkg.sv
// Shared constants, FSM state encoding and length clamp for the PCI bus arbiter.
package pci_bus_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StArb   = 3'd1;
  localparam state_t StAddr  = 3'd2;
  localparam state_t StWdata = 3'd3;
  localparam state_t StTurn  = 3'd4;
  localparam state_t StRdata = 3'd5;
  localparam state_t StDone  = 3'd6;

  // Zero-length requests still move one word.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    if (len == 8'd0)         return 8'd1;
    else if (len > max_len)  return max_len;
    else                     return len;
  endfunction

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// Local-requester handshake bundle between the two masters and the bus arbiter.
interface pci_bus_arbiter_if;
  import pci_bus_pkg::*;

  logic [1:0]       req;
  logic [1:0]       wr;
  logic [63:0]      addr;
  logic [15:0]      len;
  logic [63:0]      wdata;
  logic [1:0]       gnt;
  logic [1:0]       wdata_rd;
  logic [BUS_W-1:0] rdata;
  logic [1:0]       rdata_vld;
  logic [1:0]       done;

  modport master (
    output req, wr, addr, len, wdata,
    input  gnt, wdata_rd, rdata, rdata_vld, done
  );

  modport slave (
    input  req, wr, addr, len, wdata,
    output gnt, wdata_rd, rdata, rdata_vld, done
  );

endinterface

// File: rtl/pci_rr_arb.sv
// Two-way round-robin selector; the pointer moves past the grantee on release.
module pci_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  input  logic       done_idx_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = ~done_idx_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

  assign gnt_vld_o = |req_i;
  assign gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;

endmodule

// File: rtl/pci_bus_arbiter.sv
// Initiator-side arbiter/sequencer for the frame/c_be/adbus RAM bus.
// Optional early burst termination when the other side waits: PCI_ARB_LAT_TIMER_EN.
module pci_bus_arbiter
  import pci_bus_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned LAT_TIMER = 4
) (
  input  logic             clk,
  input  logic             rst,
  pci_bus_arbiter_if.slave bus,
  output logic             frame,
  output logic [3:0]       c_be,
  inout  wire [BUS_W-1:0]  adbus
);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             wr_q, wr_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       turn_q, turn_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic [1:0]       vld_q, vld_d;

  logic             gnt_vld, gnt_idx, arb_adv;
  logic             data_phase, last_phase;
  logic [1:0]       sel_oh;
  logic             adbus_oe;
  logic [BUS_W-1:0] adbus_out;

  pci_rr_arb u_rr (
    .clk_i      (clk),
    .rst_ni     (rst),
    .req_i      (bus.req),
    .adv_i      (arb_adv),
    .done_idx_i (sel_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_idx_o  (gnt_idx)
  );

  assign sel_oh     = sel_q ? 2'b10 : 2'b01;
  assign data_phase = (state_q == StWdata) || (state_q == StRdata);

`ifdef PCI_ARB_LAT_TIMER_EN
  logic [7:0] ph_q, ph_d;

  always_comb begin
    ph_d = ph_q;
    if (state_q == StArb)   ph_d = 8'd0;
    else if (data_phase)    ph_d = ph_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ph_q <= 8'd0;
    else      ph_q <= ph_d;
  end

  assign last_phase = (cnt_q == 8'd1) ||
                      (bus.req[~sel_q] && (ph_q == 8'(LAT_TIMER - 1)));
`else
  logic unused_lat_timer;
  assign unused_lat_timer = ^LAT_TIMER;
  assign last_phase       = (cnt_q == 8'd1);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    rdata_d = rdata_q;
    vld_d   = 2'b00;
    arb_adv = 1'b0;
    case (state_q)
      StIdle: if (|bus.req) state_d = StArb;
      StArb: begin
        if (gnt_vld) begin
          sel_d   = gnt_idx;
          wr_d    = bus.wr[gnt_idx];
          addr_d  = gnt_idx ? bus.addr[63:32] : bus.addr[31:0];
          cnt_d   = clamp_len(gnt_idx ? bus.len[15:8] : bus.len[7:0], 8'(MAX_LEN));
          state_d = StAddr;
        end else begin
          state_d = StIdle;
        end
      end
      StAddr: begin
        if (wr_q)             state_d = StWdata;
        else if (RD_LAT == 0) state_d = StRdata;
        else begin
          turn_d  = 8'(RD_LAT - 1);
          state_d = StTurn;
        end
      end
      StTurn: begin
        if (turn_q == 8'd0) state_d = StRdata;
        else                turn_d  = turn_q - 8'd1;
      end
      StWdata, StRdata: begin
        // cnt_q is at least 1 in a data phase, so the decrement cannot wrap.
        cnt_d = cnt_q - 8'd1;
        if (state_q == StRdata) begin
          rdata_d = adbus;
          vld_d   = sel_oh;
        end
        if (last_phase) state_d = StDone;
      end
      StDone: begin
        arb_adv = 1'b1;
        state_d = (|bus.req) ? StArb : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= 8'd0;
      turn_q  <= 8'd0;
      rdata_q <= '0;
      vld_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      rdata_q <= rdata_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    frame     = ~((state_q == StAddr) || (state_q == StTurn) || (data_phase && !last_phase));
    c_be      = 4'b0000;
    adbus_oe  = 1'b0;
    adbus_out = '0;
    if (state_q == StAddr) begin
      c_be      = wr_q ? CMD_MEM_WR : CMD_MEM_RD;
      adbus_oe  = 1'b1;
      adbus_out = addr_q;
    end else if (state_q == StWdata) begin
      adbus_oe  = 1'b1;
      adbus_out = sel_q ? bus.wdata[63:32] : bus.wdata[31:0];
    end
  end

  assign adbus = adbus_oe ? adbus_out : {BUS_W{1'bz}};

  assign bus.gnt       = ((state_q == StAddr) || (state_q == StTurn) || data_phase) ? sel_oh
                                                                                  : 2'b00;
  assign bus.wdata_rd  = (state_q == StWdata) ? sel_oh : 2'b00;
  assign bus.done      = (state_q == StDone) ? sel_oh : 2'b00;
  assign bus.rdata     = rdata_q;
  assign bus.rdata_vld = vld_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter with a small RAM target model on adbus.
module tb_pci_bus_arbiter;

  localparam int RD_LAT = 2;
  localparam logic [31:0] PULLED = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        frame;
  logic [3:0]  c_be;
  wire  [31:0] adbus;

  pci_bus_arbiter_if bus ();

  pci_bus_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .frame (frame),
    .c_be  (c_be),
    .adbus (adbus)
  );

  for (genvar gi = 0; gi < 32; gi++) begin : g_pu
    pullup (adbus[gi]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Show-ahead write sources: word = base + number of pops so far in this grant.
  logic [31:0] wbase0, wbase1;
  logic [31:0] w_idx0, w_idx1;
  assign bus.wdata = {wbase1 + w_idx1, wbase0 + w_idx0};

  always @(posedge clk) begin
    if (bus.wdata_rd[0])  w_idx0 <= w_idx0 + 1;
    else if (!bus.gnt[0]) w_idx0 <= 0;
    if (bus.wdata_rd[1])  w_idx1 <= w_idx1 + 1;
    else if (!bus.gnt[1]) w_idx1 <= 0;
  end

  // RAM target: 0 idle, 1 write data, 2 turnaround, 3 read data.
  logic [31:0] mem [256];
  logic [1:0]  t_mode;
  logic [7:0]  t_addr;
  int          t_cnt;
  logic        tgt_oe;
  logic [31:0] tgt_data;
  assign adbus = tgt_oe ? tgt_data : 32'hzzzz_zzzz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_mode <= 2'd0;
      tgt_oe <= 1'b0;
      t_cnt  <= 0;
      t_addr <= 8'd0;
    end else if (!frame && c_be != 4'b0000) begin
      t_addr <= adbus[7:0];
      t_cnt  <= 0;
      t_mode <= (c_be == 4'b0111) ? 2'd1 : 2'd2;
    end else if (t_mode == 2'd1) begin
      mem[t_addr] <= adbus;
      t_addr      <= t_addr + 8'd1;
      if (frame) t_mode <= 2'd0;
    end else if (t_mode == 2'd2) begin
      t_cnt <= t_cnt + 1;
      if (t_cnt + 1 == RD_LAT) begin
        tgt_oe   <= 1'b1;
        tgt_data <= mem[t_addr];
        t_mode   <= 2'd3;
      end
    end else if (t_mode == 2'd3) begin
      if (frame) begin
        tgt_oe <= 1'b0;
        t_mode <= 2'd0;
      end else begin
        t_addr   <= t_addr + 8'd1;
        tgt_data <= mem[t_addr + 8'd1];
      end
    end
  end

  logic gnt_both = 1'b0;
  always @(negedge clk) if (bus.gnt == 2'b11) gnt_both <= 1'b1;

  // Called at a negedge; runs one burst cycle by cycle and leaves at the DONE negedge.
  task automatic burst(input int r, input bit w, input logic [31:0] a, input logic [7:0] l,
                       input int phases, input logic [31:0] dbase);
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    if (r == 0) begin
      bus.addr[31:0] = a; bus.len[7:0] = l; wbase0 = dbase;
    end else begin
      bus.addr[63:32] = a; bus.len[15:8] = l; wbase1 = dbase;
    end
    bus.wr[r]  = w;
    bus.req[r] = 1'b1;
    @(negedge clk);
    check("arb_gnt", bus.gnt, 2'b00);
    @(negedge clk);
    check("addr_frame", frame, 1'b0);
    check("addr_cbe", c_be, w ? 4'b0111 : 4'b0110);
    check("addr_bus", adbus, a);
    check("addr_gnt", bus.gnt, oh);
    if (!w) begin
      for (int t = 0; t < RD_LAT; t++) begin
        @(negedge clk);
        check("turn_frame", frame, 1'b0);
        check("turn_z", adbus, PULLED);
      end
    end
    for (int i = 0; i < phases; i++) begin
      @(negedge clk);
      check("data_frame", frame, (i == phases - 1) ? 1'b1 : 1'b0);
      if (w) begin
        check("wr_data", adbus, dbase + i);
        check("wr_pop", bus.wdata_rd, oh);
      end else begin
        check("rd_vld", bus.rdata_vld, (i == 0) ? 2'b00 : oh);
        if (i > 0) check("rd_data", bus.rdata, dbase + i - 1);
      end
    end
    @(negedge clk);
    check("done_pulse", bus.done, oh);
    check("done_gnt", bus.gnt, 2'b00);
    check("done_frame", frame, 1'b1);
    check("done_cbe", c_be, 4'b0000);
    check("done_z", adbus, PULLED);
    if (!w) begin
      check("rd_last_vld", bus.rdata_vld, oh);
      check("rd_last", bus.rdata, dbase + phases - 1);
    end
    bus.req[r] = 1'b0;
  endtask

  task automatic wait_done(output logic [1:0] who);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.done == 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    who = bus.done;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  logic [1:0] who;
  logic [1:0] exp_seq [4];

  initial begin
    rst = 1'b0;
    bus.req = 2'b00; bus.wr = 2'b00; bus.addr = '0; bus.len = '0;
    wbase0 = '0; wbase1 = '0;
    #1;
    check("rst_frame", frame, 1'b1);
    check("rst_cbe", c_be, 4'b0000);
    check("rst_z", adbus, PULLED);
    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_done", bus.done, 2'b00);
    check("rst_vld", bus.rdata_vld, 2'b00);
    check("rst_rdata", bus.rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    burst(0, 1'b1, 32'h10, 8'd3, 3, 32'hA);
    @(negedge clk);
    check("ram_10", mem[8'h10], 32'hA);
    check("ram_11", mem[8'h11], 32'hB);
    check("ram_12", mem[8'h12], 32'hC);

    burst(1, 1'b0, 32'h10, 8'd3, 3, 32'hA);
    burst(0, 1'b1, 32'h20, 8'd0, 1, 32'h50);
    burst(1, 1'b1, 32'h40, 8'd40, 16, 32'h100);
    @(negedge clk);
    check("ram_4f", mem[8'h4F], 32'h10F);

    // Reset during the second write data phase.
    bus.addr[31:0] = 32'h80; bus.len[7:0] = 8'd4; bus.wr[0] = 1'b1; wbase0 = 32'h300;
    bus.req[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_w2", adbus, 32'h301);
    rst = 1'b0;
    bus.req = 2'b00;
    #1;
    check("midrst_frame", frame, 1'b1);
    check("midrst_z", adbus, PULLED);
    check("midrst_gnt", bus.gnt, 2'b00);
    check("midrst_pop", bus.wdata_rd, 2'b00);
    @(negedge clk);
    check("midrst_done", bus.done, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_done", bus.done, 2'b00);
    burst(0, 1'b0, 32'h10, 8'd3, 3, 32'hA);

    // Contention from reset: pointer side first, then alternate.
    do_reset();
    bus.addr = {32'hA0, 32'h90}; bus.len = {8'd1, 8'd1}; bus.wr = 2'b11;
    wbase0 = 32'h700; wbase1 = 32'h800;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(who);
      check("rr_order", who, exp_seq[k]);
    end
    bus.req = 2'b00;
    check("gnt_onehot", gnt_both, 1'b0);
    check("ram_90", mem[8'h90], 32'h700);
    check("ram_a0", mem[8'hA0], 32'h800);

`ifdef PCI_ARB_LAT_TIMER_EN
    bus.addr[63:32] = 32'h10; bus.len[15:8] = 8'd1; bus.wr[1] = 1'b0;
    bus.req[1] = 1'b1;
    burst(0, 1'b1, 32'h60, 8'd10, 4, 32'h200);
    repeat (2) @(negedge clk);
    check("lat_gnt1", bus.gnt, 2'b10);
    wait_done(who);
    check("lat_done1", who, 2'b10);
    bus.req = 2'b00;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
